mpsoc_apb_gpio_irq: RTL and testbench
=====================================

MPSOC_APB_GPIO_IRQ -- requirements
Module: mpsoc_apb_gpio_irq

Interface
REQ-001 SHALL have parameter PADDR_SIZE, default 64, APB address width.
REQ-002 SHALL have parameter PDATA_SIZE, default 32, APB data width and GPIO pin count; multiple of 8.
REQ-003 SHALL have port PCLK  input  1  APB clock; all logic in this domain.
REQ-004 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have APB-Lite slave ports, all inputs unless stated: PSEL 1, PENABLE 1, PWRITE 1, PSTRB PDATA_SIZE/8, PADDR PADDR_SIZE, PWDATA PDATA_SIZE, PRDATA output PDATA_SIZE, PREADY output 1, PSLVERR output 1.
REQ-006 SHALL have port gpio_i  input  PDATA_SIZE  raw asynchronous pin levels, same net as the GPIO block inputs.
REQ-007 SHALL have port irq_o  output  1  level interrupt request, registered.

Function
REQ-008 SHALL tie PREADY=1 (zero wait states) and PSLVERR=0.
REQ-009 SHALL decode register select from PADDR[3:2]: 0=IEN (interrupt enable), 1=RISE (rising-edge enable), 2=FALL (falling-edge enable), 3=PEND (pending); PADDR[1:0] and upper bits ignored.
REQ-010 SHALL perform a write when PSEL & PENABLE & PWRITE, updating only byte lanes with PSTRB[i]=1.
REQ-011 SHALL write IEN, RISE and FALL as plain read/write registers.
REQ-012 SHALL treat PEND writes as write-1-to-clear: bit k cleared iff written byte lane enabled and PWDATA[k]=1; 0 bits unaffected.
REQ-013 SHALL drive PRDATA combinationally from PADDR[3:2] while PSEL=1; PRDATA=0 when PSEL=0.
REQ-014 SHALL synchronise gpio_i through 3 flip-flop stages (sync0..sync2), then hold one delayed copy prev = sync2 of previous cycle.
REQ-015 SHALL detect rise[k] = sync2[k] & ~prev[k] & RISE[k]; fall[k] = ~sync2[k] & prev[k] & FALL[k].
REQ-016 SHALL set PEND[k] on the clock edge after rise[k]|fall[k], independent of IEN[k].
REQ-017 SHALL give set priority over clear: edge and W1C on same bit in same cycle leaves PEND[k]=1.
REQ-018 SHALL compute irq_o registered: irq_o <= |(PEND & IEN), one cycle after PEND/IEN change.
REQ-019 SHALL latency: gpio_i change settled before PCLK edge 1 -> PEND bit set after edge 4, irq_o high after edge 5.
REQ-020 SHALL ignore pulses on gpio_i shorter than one PCLK period only to the extent the synchroniser misses them; no glitch filter.
REQ-021 SHALL, with RISE[k]=FALL[k]=1, flag both edges; with both 0, never set PEND[k].
REQ-022 SHALL suppress edge detection for the first 4 cycles after reset release (prev and sync reset to 0; a pin held high from reset SHALL NOT produce a rising edge): enforced by a 3-bit warm-up counter that gates rise/fall until it saturates at 4.

Reset
REQ-023 SHALL on PRESETn=0 asynchronously clear IEN, RISE, FALL, PEND, sync0..sync2, prev, warm-up counter and irq_o to 0.
REQ-024 SHALL, on reset asserted mid-operation, drop irq_o and all pending bits immediately without waiting for PCLK.

Verification
REQ-025 SHALL verify: write RISE=0x1, IEN=0x1; gpio_i[0] 0->1 -> PEND=0x1 after edge 4, irq_o=1 after edge 5.
REQ-026 SHALL verify: FALL=0x8000_0000, IEN=0; gpio_i[31] 1->0 -> PEND=0x8000_0000, irq_o stays 0; then write IEN=0x8000_0000 -> irq_o=1 next cycle.
REQ-027 SHALL verify: PEND=0x3, write PEND=0x1 with PSTRB=0x1 -> PEND=0x2; write 0x2 with PSTRB=0x0 -> PEND remains 0x2.
REQ-028 SHALL verify: W1C of PEND[0] in same cycle as new rising edge on pin 0 -> PEND[0]=1.
REQ-029 SHALL verify: gpio_i=0xFFFF_FFFF during and after reset, RISE=0xFFFF_FFFF -> PEND stays 0.
REQ-030 SHALL verify: irq_o=1, assert PRESETn=0 between clock edges -> irq_o=0 and all registers read 0 after release.

Source files
------------

// File: rtl/mpsoc_apb_gpio_irq.sv
// Purpose : APB-Lite GPIO edge-interrupt controller (IEN/RISE/FALL/PEND registers, level irq_o).
// Latency : pin change -> PEND set 4 PCLK edges later, irq_o one edge after PEND/IEN change.
// Backpressure: none, PREADY tied high (zero wait states), PSLVERR tied low.
//
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   PSEL..PWDATA             APB-Lite request (PADDR[3:2] selects IEN/RISE/FALL/PEND)
//   PRDATA, PREADY, PSLVERR  APB-Lite response
//   gpio_i                   raw asynchronous pin levels
//   irq_o                    registered level interrupt: |(PEND & IEN)
module mpsoc_apb_gpio_irq #(
    parameter int PADDR_SIZE = 64,
    parameter int PDATA_SIZE = 32
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [PDATA_SIZE-1:0]   gpio_i,
    output logic                    irq_o
);

    localparam logic [1:0] REG_IEN  = 2'd0;
    localparam logic [1:0] REG_RISE = 2'd1;
    localparam logic [1:0] REG_FALL = 2'd2;
    localparam logic [1:0] REG_PEND = 2'd3;
    localparam logic [2:0] WARM_DONE = 3'd4;

    logic [PDATA_SIZE-1:0] ien_q, ien_d;
    logic [PDATA_SIZE-1:0] rise_q, rise_d;
    logic [PDATA_SIZE-1:0] fall_q, fall_d;
    logic [PDATA_SIZE-1:0] pend_q, pend_d;
    logic [PDATA_SIZE-1:0] sync0_q, sync1_q, sync2_q, prev_q;
    logic [2:0]            warm_q, warm_d;
    logic                  irq_q, irq_d;

    logic [1:0]            reg_sel;
    logic                  wr_en;
    logic [PDATA_SIZE-1:0] lane_mask;
    logic [PDATA_SIZE-1:0] clr_vec;
    logic [PDATA_SIZE-1:0] set_vec;
    logic                  edge_en;
    logic                  unused_paddr;

    assign reg_sel      = PADDR[3:2];
    assign unused_paddr = ^{PADDR[PADDR_SIZE-1:4], PADDR[1:0]};
    assign wr_en        = PSEL & PENABLE & PWRITE;
    assign PREADY       = 1'b1;
    assign PSLVERR      = 1'b0;
    assign irq_o        = irq_q;

    // Expand byte strobes into a per-bit write mask.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < PDATA_SIZE/8; i++) begin
            lane_mask[i*8 +: 8] = {8{PSTRB[i]}};
        end
    end

    // Edge detection stays gated until the synchroniser and prev stage
    // have been refilled with real pin samples after reset release.
    assign edge_en = (warm_q == WARM_DONE);
    assign warm_d  = edge_en ? warm_q : warm_q + 3'd1;

    assign set_vec = edge_en ? ((sync2_q & ~prev_q & rise_q) |
                                (~sync2_q & prev_q & fall_q)) : '0;

    always_comb begin
        ien_d   = ien_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        clr_vec = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_IEN:  ien_d   = (ien_q  & ~lane_mask) | (PWDATA & lane_mask);
                REG_RISE: rise_d  = (rise_q & ~lane_mask) | (PWDATA & lane_mask);
                REG_FALL: fall_d  = (fall_q & ~lane_mask) | (PWDATA & lane_mask);
                default:  clr_vec = PWDATA & lane_mask;
            endcase
        end
        // A new edge wins over a simultaneous write-1-to-clear.
        pend_d = (pend_q & ~clr_vec) | set_vec;
        irq_d  = |(pend_q & ien_q);
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (reg_sel)
                REG_IEN:  PRDATA = ien_q;
                REG_RISE: PRDATA = rise_q;
                REG_FALL: PRDATA = fall_q;
                default:  PRDATA = pend_q;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ien_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            sync0_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            ien_q   <= ien_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            sync0_q <= gpio_i;
            sync1_q <= sync0_q;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            warm_q  <= warm_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_mpsoc_apb_gpio_irq.sv
// Self-checking bench for mpsoc_apb_gpio_irq: register table vectors, directed
// edge/latency/reset sequences and randomized traffic against a history-based model.
module tb_mpsoc_apb_gpio_irq;
    localparam int AW = 64;
    localparam int DW = 32;

    logic          PCLK;
    logic          PRESETn;
    logic          PSEL, PENABLE, PWRITE;
    logic [3:0]    PSTRB;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;
    logic [DW-1:0] gpio_i;
    logic          irq_o;

    mpsoc_apb_gpio_irq #(.PADDR_SIZE(AW), .PDATA_SIZE(DW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .gpio_i(gpio_i), .irq_o(irq_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: registers plus the full history of pin samples
    // taken at each clock edge since reset release.
    logic [31:0] m_ien, m_rise, m_fall, m_pend;
    logic        m_irq;
    logic [31:0] hist[$];

    typedef struct {
        logic [1:0]  r;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ien = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
        hist.delete();
    endfunction

    function automatic logic [31:0] mreg(input logic [1:0] r);
        case (r)
            2'd0:    return m_ien;
            2'd1:    return m_rise;
            2'd2:    return m_fall;
            default: return m_pend;
        endcase
    endfunction

    // Edge n after release sees the pin as sampled at edge n-3 and compares it
    // with the sample from edge n-4; the first four edges never flag anything.
    function automatic void model_edge();
        logic [31:0] s2, p, setv, clrv, bm;
        logic        irq_next;
        int          n;
        n = hist.size() + 1;
        setv = '0;
        if (n >= 5) begin
            s2   = hist[n-4];
            p    = hist[n-5];
            setv = (m_rise & s2 & ~p) | (m_fall & ~s2 & p);
        end
        for (int i = 0; i < 4; i++) bm[i*8 +: 8] = {8{PSTRB[i]}};
        irq_next = |(m_pend & m_ien);
        clrv = '0;
        if (PSEL && PENABLE && PWRITE) begin
            case (PADDR[3:2])
                2'd0:    m_ien  = (m_ien  & ~bm) | (PWDATA & bm);
                2'd1:    m_rise = (m_rise & ~bm) | (PWDATA & bm);
                2'd2:    m_fall = (m_fall & ~bm) | (PWDATA & bm);
                default: clrv   = PWDATA & bm;
            endcase
        end
        m_pend = (m_pend & ~clrv) | setv;
        m_irq  = irq_next;
        hist.push_back(gpio_i);
    endfunction

    // One clock: model follows the posedge, outputs checked at the negedge.
    task automatic step();
        @(posedge PCLK);
        if (PRESETn) model_edge();
        else         model_reset();
        @(negedge PCLK);
        chk("irq_model", {31'd0, irq_o}, {31'd0, m_irq});
    endtask

    task automatic set_addr(input logic [1:0] r);
        PADDR = {$urandom, $urandom};
        PADDR[3:2] = r;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        set_addr(r); PWDATA = d; PSTRB = s;
        step();
        PENABLE = 1'b1;
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Combinational read inside the current low phase; consumes no clock.
    task automatic rd(input logic [1:0] r, input logic [31:0] exp, input string name);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        set_addr(r);
        #1;
        chk(name, PRDATA, exp);
        PSEL = 1'b0;
    endtask

    int          c;
    logic [1:0]  rr;

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PSTRB = '0; PADDR = '0; PWDATA = '0; gpio_i = '0;
        model_reset();
        step(); step();
        PRESETn = 1'b1;

        // Reset state
        rd(2'd0, 32'h0, "rst_ien");
        rd(2'd1, 32'h0, "rst_rise");
        rd(2'd2, 32'h0, "rst_fall");
        rd(2'd3, 32'h0, "rst_pend");
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("pready", {31'd0, PREADY}, 32'd1);
        chk("pslverr", {31'd0, PSLVERR}, 32'd0);
        repeat (6) step();

        // Register access vectors (pins quiet, so PEND never sets)
        tbl[0] = '{2'd0, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
        tbl[1] = '{2'd0, 32'hFFFFFFFF, 4'h1, 32'hA5A5A5FF};
        tbl[2] = '{2'd0, 32'h00000000, 4'hA, 32'h00A500FF};
        tbl[3] = '{2'd1, 32'h12345678, 4'h6, 32'h00345600};
        tbl[4] = '{2'd1, 32'hFFFFFFFF, 4'h0, 32'h00345600};
        tbl[5] = '{2'd2, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        tbl[6] = '{2'd2, 32'h00000000, 4'hC, 32'h0000BEEF};
        tbl[7] = '{2'd3, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        for (int i = 0; i < 8; i++) begin
            wr(tbl[i].r, tbl[i].wd, tbl[i].strb);
            rd(tbl[i].r, tbl[i].exp, $sformatf("tbl%0d", i));
        end
        PSEL = 1'b0; set_addr(2'd0); #1;
        chk("prdata_idle", PRDATA, 32'h0);
        wr(2'd0, 0, 4'hF); wr(2'd1, 0, 4'hF); wr(2'd2, 0, 4'hF);

        // Rising edge latency on pin 0
        wr(2'd1, 32'h1, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        gpio_i[0] = 1'b1;
        step(); step(); step();
        rd(2'd3, 32'h0, "rise_pend_edge3");
        step();
        rd(2'd3, 32'h1, "rise_pend_edge4");
        chk("rise_irq_edge4", {31'd0, irq_o}, 32'd0);
        step();
        chk("rise_irq_edge5", {31'd0, irq_o}, 32'd1);
        wr(2'd3, 32'h1, 4'hF); wr(2'd0, 0, 4'hF); wr(2'd1, 0, 4'hF);
        gpio_i[0] = 1'b0;
        repeat (5) step();

        // Falling edge on pin 31 with interrupt masked, then unmasked
        gpio_i[31] = 1'b1;
        repeat (6) step();
        wr(2'd2, 32'h8000_0000, 4'hF);
        gpio_i[31] = 1'b0;
        step(); step(); step();
        rd(2'd3, 32'h0, "fall_pend_edge3");
        step();
        rd(2'd3, 32'h8000_0000, "fall_pend_edge4");
        repeat (3) step();
        chk("fall_irq_masked", {31'd0, irq_o}, 32'd0);
        wr(2'd0, 32'h8000_0000, 4'hF);
        chk("fall_irq_same", {31'd0, irq_o}, 32'd0);
        step();
        chk("fall_irq_unmask", {31'd0, irq_o}, 32'd1);
        wr(2'd3, 32'hFFFF_FFFF, 4'hF); wr(2'd0, 0, 4'hF); wr(2'd2, 0, 4'hF);
        step(); step();

        // W1C with byte strobes
        wr(2'd1, 32'h3, 4'hF);
        gpio_i[1:0] = 2'b11;
        repeat (5) step();
        rd(2'd3, 32'h3, "w1c_pre");
        wr(2'd3, 32'h1, 4'h1);
        rd(2'd3, 32'h2, "w1c_lane");
        wr(2'd3, 32'h2, 4'h0);
        rd(2'd3, 32'h2, "w1c_nostrb");
        wr(2'd1, 32'h1, 4'hF);
        gpio_i[1:0] = 2'b00;
        wr(2'd3, 32'h2, 4'hF);
        repeat (4) step();
        rd(2'd3, 32'h0, "w1c_clear");

        // Clear and edge on pin 0 land on the same clock edge
        gpio_i[0] = 1'b1;
        step(); step();
        wr(2'd3, 32'h1, 4'hF);
        rd(2'd3, 32'h1, "set_beats_clr");
        gpio_i[0] = 1'b0;
        wr(2'd1, 0, 4'hF);
        wr(2'd3, 32'hFFFF_FFFF, 4'hF);

        // Asynchronous reset while irq_o is high
        wr(2'd1, 32'h1, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        gpio_i[0] = 1'b1;
        repeat (6) step();
        chk("pre_reset_irq", {31'd0, irq_o}, 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("async_irq_drop", {31'd0, irq_o}, 32'd0);
        rd(2'd3, 32'h0, "async_pend_drop");
        model_reset();
        step(); step();
        PRESETn = 1'b1;
        rd(2'd0, 32'h0, "post_rst_ien");
        rd(2'd1, 32'h0, "post_rst_rise");
        rd(2'd2, 32'h0, "post_rst_fall");
        rd(2'd3, 32'h0, "post_rst_pend");

        // Pins held high across reset must not look like a rising edge
        gpio_i = 32'hFFFF_FFFF;
        PRESETn = 1'b0;
        step(); step();
        PRESETn = 1'b1;
        wr(2'd1, 32'hFFFF_FFFF, 4'hF);
        wr(2'd0, 32'hFFFF_FFFF, 4'hF);
        repeat (6) step();
        rd(2'd3, 32'h0, "warmup_pend");
        chk("warmup_irq", {31'd0, irq_o}, 32'd0);

        // Randomized traffic against the model
        wr(2'd2, $urandom, 4'hF);
        for (int i = 0; i < 800; i++) begin
            c  = int'($urandom_range(0, 9));
            rr = 2'($urandom_range(0, 3));
            if (c < 4) begin
                gpio_i = gpio_i ^ ($urandom & $urandom);
                step();
            end else if (c < 6) begin
                wr(rr, $urandom, 4'($urandom));
            end else if (c < 8) begin
                rd(rr, mreg(rr), "rand_rd");
                step();
            end else begin
                step();
            end
        end
        for (int r = 0; r < 4; r++) rd(2'(r), mreg(2'(r)), "final_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
